fifo_sync_wm: RTL and testbench
===============================

Name: fifo_sync_wm

Overview:
- Parametrised synchronous FIFO. It is the successor to the flat addressed memory in the PCIE_2 datapath.
- Wraps a dual-port register-file sub-module behind internal read/write pointers.
- Adds occupancy count, full/empty flags, programmable almost-full/almost-empty watermarks and sticky overflow/underflow error flags.
- Sits between PCIe lane/link-layer stages as the standard elastic buffer, and is driven by the same probador-style benches.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- ADDR_SIZE, 3, pointer width; depth = 2**ADDR_SIZE.
- DEPTH, 8, number of entries; must equal 2**ADDR_SIZE (elaboration check).
- AF_TH, 6, almost_full asserts when count >= AF_TH (1..DEPTH).
- AE_TH, 2, almost_empty asserts when count <= AE_TH (0..DEPTH-1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_enb  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_enb  input  1  read request.
- data_out  output  DATA_WIDTH  read data, registered.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_TH.
- almost_empty  output  1  count <= AE_TH.
- count  output  ADDR_SIZE+1  current occupancy 0..DEPTH.
- err_overflow  output  1  sticky: a write was dropped.
- err_underflow  output  1  sticky: a read was dropped.
- max_count  output  ADDR_SIZE+1  peak occupancy (optional feature only; otherwise 0).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (rst high at an edge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, err_overflow=0, err_underflow=0, max_count=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
- Storage contents are not cleared by reset. Reset mid-operation discards all entries.
- Flags are combinational from count; count is registered.
- Write accepted (wr_ok) when wr_enb & (~full | rd_ok). The word goes to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Read accepted (rd_ok) when rd_enb & ~empty. data_out <= mem[rd_ptr] and valid_out <= 1 on that edge, so latency is 1 cycle from rd_enb. rd_ptr increments modulo DEPTH.
- If no read is accepted, valid_out <= 0 and data_out holds its last value.
- count update: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
- Full with wr_enb and rd_enb together: both accepted, count stays DEPTH, no error.
- Empty with wr_enb and rd_enb together: only the write is accepted. count becomes 1 and err_underflow sets. There is no read-through.
- wr_enb while full without rd_ok: data dropped, pointers unchanged, err_overflow <= 1.
- rd_enb while empty: err_underflow <= 1, data_out unchanged, valid_out <= 0.
- Error flags clear only on rst.
- Pointer wrap: from DEPTH-1 to 0. Full/empty are decided from count, never from pointer equality.

Optional Feature:
- Macro FIFO_PEAK_MON_EN.
- Defined: max_count <= max(max_count, next count) every cycle. It resets to 0, is sticky otherwise, and is used for buffer sizing during link bring-up.
- Not defined: max_count tied to 0 and no comparator logic is synthesised.
- The port list is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - default constants DATA_WIDTH_DEF=10, ADDR_SIZE_DEF=3;
  - a function clog2 for benches deriving ADDR_SIZE;
  - localparam computing count width ADDR_SIZE+1.
- One sub-module, fifo_mem_dp: DEPTH x DATA_WIDTH array.
  - Ports: clk, wr_enb, wr_addr, data_in, rd_enb, rd_addr, data_out.
  - Synchronous write; registered read.
  - No reset on the array.
- The top holds pointers, count, flags and errors.

Test Plan:
1. Reset then fill: rst 2 cycles, then write 0x001..0x008 on consecutive cycles. Expect count 1..8; almost_full rises on the 6th write; full=1 after the 8th; err_overflow=0.
2. Overflow: from full, write 0x3FF with rd_enb=0. Expect count stays 8, err_overflow=1. A subsequent drain returns 0x001..0x008 in order, and 0x3FF never appears.
3. Drain and underflow: read 9 times from full.
   - data_out = 0x001..0x008, each with valid_out one cycle after rd_enb.
   - almost_empty rises when count reaches 2; empty after the 8th read.
   - The 9th read sets err_underflow, with valid_out=0.
4. Simultaneous at boundaries:
   - Full + wr/rd: count stays 8, oldest word out, new word stored at the tail.
   - Empty + wr/rd: count=1, err_underflow=1, and the next read returns the written word.
5. Wrap-around: 20 cycles alternating 3 writes / 2 reads with incrementing data. Expect strict FIFO order across pointer wrap, and count matches the reference model each cycle.
6. Reset mid-operation: with count=5, assert rst for 1 cycle together with wr_enb=1. Expect count=0, empty=1, errors=0, and the write ignored. With FIFO_PEAK_MON_EN defined, max_count=5 before rst and 0 after.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_sync_wm elastic buffer and its benches.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned ADDR_SIZE_DEF  = 3;
  localparam int unsigned COUNT_W_DEF    = ADDR_SIZE_DEF + 1;

  // Ceiling log2, used by benches to derive ADDR_SIZE from a depth.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned count_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port register file: synchronous write, registered read, no reset on storage.
module fifo_mem_dp #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_SIZE  = 3,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  wr_enb,
  input  logic [ADDR_SIZE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Read sees pre-write contents, so a same-address write/read returns the old word.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_enb) mem_d[wr_addr] = data_in;
    if (rd_enb) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rd_data_q <= rd_data_d;
  end

  assign data_out = rd_data_q;

endmodule

// File: rtl/fifo_sync_wm.sv
// Synchronous FIFO with occupancy count, watermarks and sticky error flags.
// Optional peak-occupancy monitor enabled by defining FIFO_PEAK_MON_EN.
module fifo_sync_wm
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_TH      = 6,
  parameter int unsigned AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_SIZE:0]    max_count
);

  localparam int unsigned CNT_W = count_width(ADDR_SIZE);

  if (DEPTH != (1 << ADDR_SIZE)) begin : g_depth_chk
    $error("fifo_sync_wm: DEPTH must equal 2**ADDR_SIZE");
  end

  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_seen_q, rd_seen_d;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_TH));
  assign almost_empty = (count_q <= CNT_W'(AE_TH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  always_comb begin
    rd_ok     = rd_enb & ~empty;
    wr_ok     = wr_enb & (~full | rd_ok);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    valid_d   = rd_ok;
    rd_seen_d = rd_seen_q | rd_ok;
    ovf_d     = ovf_q | (wr_enb & ~wr_ok);
    udf_d     = udf_q | (rd_enb & ~rd_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      rd_seen_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      rd_seen_q <= rd_seen_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_enb   (wr_ok & ~rst),
    .wr_addr  (wr_ptr_q),
    .data_in  (data_in),
    .rd_enb   (rd_ok & ~rst),
    .rd_addr  (rd_ptr_q),
    .data_out (mem_rd_data)
  );

  // Storage has no reset; data_out reads as zero until the first pop after reset.
  assign data_out      = rd_seen_q ? mem_rd_data : '0;
  assign valid_out     = valid_q;
  assign count         = count_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

`ifdef FIFO_PEAK_MON_EN
  logic [CNT_W-1:0] max_count_q, max_count_d;

  always_comb begin
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) max_count_q <= '0;
    else     max_count_q <= max_count_d;
  end

  assign max_count = max_count_q;
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_wm.sv
// Self-checking bench for fifo_sync_wm: vector table, directed corners and random traffic vs a queue model.
module tb_fifo_sync_wm;
  import fifo_pkg::*;

  localparam int unsigned DW    = DATA_WIDTH_DEF;
  localparam int unsigned AW    = clog2(8);
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic          clk, rst, wr_enb, rd_enb;
  logic [DW-1:0] data_in, data_out;
  logic          valid_out, full, empty, almost_full, almost_empty;
  logic [AW:0]   count, max_count;
  logic          err_overflow, err_underflow;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  bit            m_valid, m_ovf, m_udf;
  int            m_peak;

  typedef struct {
    bit            rst, wr, rd;
    logic [DW-1:0] din;
    int            count;
    bit            valid;
    logic [DW-1:0] dout;
    bit            full, af, ae, empty, ovf, udf;
  } vec_t;

  vec_t vt[20];

  fifo_sync_wm #(
    .DATA_WIDTH (DW),
    .ADDR_SIZE  (AW),
    .DEPTH      (DEPTH),
    .AF_TH      (AF),
    .AE_TH      (AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_enb        (wr_enb),
    .data_in       (data_in),
    .rd_enb        (rd_enb),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .max_count     (max_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit w, logic [DW-1:0] d, bit rd, int c, bit v,
                              logic [DW-1:0] dout, bit f, bit af, bit ae, bit e, bit ov, bit ud);
    vec_t x;
    x.rst = r; x.wr = w; x.din = d; x.rd = rd; x.count = c; x.valid = v; x.dout = dout;
    x.full = f; x.af = af; x.ae = ae; x.empty = e; x.ovf = ov; x.udf = ud;
    return x;
  endfunction

  // Behavioural FIFO: decisions made on the occupancy seen before the edge.
  task automatic model_update(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    bit rd_acc, wr_acc;
    if (r) begin
      mq.delete();
      m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
      return;
    end
    rd_acc = rd && (mq.size() != 0);
    wr_acc = w && ((mq.size() < DEPTH) || rd_acc);
    m_valid = rd_acc;
    if (rd_acc) m_dout = mq.pop_front();
    if (wr_acc) mq.push_back(d);
    if (w && !wr_acc) m_ovf = 1;
    if (rd && !rd_acc) m_udf = 1;
    if (mq.size() > m_peak) m_peak = mq.size();
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("data_out", int'(data_out), int'(m_dout));
    chk("err_overflow", int'(err_overflow), int'(m_ovf));
    chk("err_underflow", int'(err_underflow), int'(m_udf));
`ifdef FIFO_PEAK_MON_EN
    chk("max_count", int'(max_count), m_peak);
`else
    chk("max_count", int'(max_count), 0);
`endif
  endtask

  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    rst = r; wr_enb = w; data_in = d; rd_enb = rd;
    @(posedge clk);
    model_update(r, w, d, rd);
    #1;
    compare_model();
  endtask

  initial begin
    logic [DW-1:0] last;
    logic [DW-1:0] seq;
    clk = 0; rst = 1; wr_enb = 0; rd_enb = 0; data_in = '0;
    tests_run = 0; tests_failed = 0;
    m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_peak = 0;

    // Reset, fill 1..8, overflow write, then nine reads
    vt[0] = mk(1, 0, '0, 0, 0, 0, '0, 0, 0, 1, 1, 0, 0);
    vt[1] = mk(1, 0, '0, 0, 0, 0, '0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      vt[2+i] = mk(0, 1, DW'(i + 1), 0, i + 1, 0, '0, i == 7, i >= 5, i <= 1, 0, 0, 0);
    vt[10] = mk(0, 1, 10'h3FF, 0, 8, 0, '0, 1, 1, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      vt[11+k] = mk(0, 0, '0, 1, 7 - k, 1, DW'(k + 1), 0, (7 - k) >= 6, (7 - k) <= 2, k == 7, 1, 0);
    vt[19] = mk(0, 0, '0, 1, 0, 0, 10'h008, 0, 0, 1, 1, 1, 1);

    for (int i = 0; i < 20; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].din, vt[i].rd);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].count);
      chk($sformatf("vec%0d_valid", i), int'(valid_out), int'(vt[i].valid));
      chk($sformatf("vec%0d_dout", i), int'(data_out), int'(vt[i].dout));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].full));
      chk($sformatf("vec%0d_af", i), int'(almost_full), int'(vt[i].af));
      chk($sformatf("vec%0d_ae", i), int'(almost_empty), int'(vt[i].ae));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].empty));
      chk($sformatf("vec%0d_ovf", i), int'(err_overflow), int'(vt[i].ovf));
      chk($sformatf("vec%0d_udf", i), int'(err_underflow), int'(vt[i].udf));
    end

    // Empty with simultaneous write/read: only the write lands
    step(1, 0, '0, 0);
    step(0, 1, 10'h155, 1);
    chk("empty_wr_rd_count", int'(count), 1);
    chk("empty_wr_rd_udf", int'(err_underflow), 1);
    chk("empty_wr_rd_valid", int'(valid_out), 0);
    step(0, 0, '0, 1);
    chk("empty_wr_rd_readback", int'(data_out), 'h155);
    chk("empty_wr_rd_readback_valid", int'(valid_out), 1);

    // Full with simultaneous write/read: oldest out, newest at tail
    for (int i = 0; i < 8; i++) step(0, 1, DW'(32'h100 + i), 0);
    chk("full_before_pair", int'(full), 1);
    step(0, 1, 10'h2AA, 1);
    chk("full_pair_count", int'(count), 8);
    chk("full_pair_dout", int'(data_out), 'h100);
    chk("full_pair_ovf", int'(err_overflow), 0);
    last = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 1);
      last = data_out;
    end
    chk("full_pair_tail", int'(last), 'h2AA);

    // Wrap-around: 3 writes / 2 reads with incrementing data
    seq = 10'h040;
    for (int i = 0; i < 20; i++) begin
      if ((i % 5) < 3) begin
        step(0, 1, seq, 0);
        seq = seq + DW'(1);
      end else begin
        step(0, 0, '0, 1);
      end
    end

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50);
    end

    // Reset mid-operation with a concurrent write
    step(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(32'h200 + i), 0);
    chk("pre_rst_count", int'(count), 5);
`ifdef FIFO_PEAK_MON_EN
    chk("pre_rst_max_count", int'(max_count), 5);
`endif
    step(1, 1, 10'h3C3, 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ovf", int'(err_overflow), 0);
    chk("mid_rst_udf", int'(err_underflow), 0);
    chk("mid_rst_max_count", int'(max_count), 0);
    step(0, 0, '0, 1);
    chk("mid_rst_write_ignored", int'(valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
